// File: rtl/counter_run_controller.sv
// counter_run_controller: runs a single up/down count from a start value to a
// terminal value. The count advances once every (prescale+1) cycles. The run
// can be paused or aborted, and a one-cycle done pulse marks normal completion.
module counter_run_controller #(
    parameter int WIDTH    = 8,
    parameter int PS_WIDTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [WIDTH-1:0]    cmd_start_val,
    input  logic [WIDTH-1:0]    cmd_term_val,
    input  logic [PS_WIDTH-1:0] cmd_prescale,
    input  logic                cmd_down,
    input  logic                pause,
    input  logic                abort,
    output logic [WIDTH-1:0]    count_out,
    output logic                busy,
    output logic                done,
    output logic [1:0]          state_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    count_q, count_d;
    logic [WIDTH-1:0]    term_q, term_d;
    logic [PS_WIDTH-1:0] pc_q, pc_d;
    logic [PS_WIDTH-1:0] ps_q, ps_d;
    logic                down_q, down_d;

    logic [WIDTH-1:0]    step_val;
    logic                pc_wrap;

    // Value the count would take after one step, and whether this edge is a step edge
    always_comb begin
        step_val = down_q ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
        pc_wrap  = (pc_q == ps_q);
    end

    // Next-state and datapath decisions; everything holds unless a rule below changes it
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        term_d  = term_q;
        pc_d    = pc_q;
        ps_d    = ps_q;
        down_d  = down_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    term_d  = cmd_term_val;
                    ps_d    = cmd_prescale;
                    down_d  = cmd_down;
                    count_d = cmd_start_val;
                    pc_d    = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (count_q == term_q) begin
                    state_d = ST_DONE;
                end else if (pause) begin
                    state_d = ST_PAUSE;
                end else if (pc_wrap) begin
                    pc_d    = '0;
                    count_d = step_val;
                end else begin
                    pc_d = pc_q + PS_WIDTH'(1);
                end
            end
            ST_PAUSE: begin
                // The release edge counts as a normal run edge, so a pause of N
                // cycles delays completion by exactly N cycles. The count cannot
                // sit at the terminal value here, since that check wins over pause.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (!pause) begin
                    state_d = ST_RUN;
                    if (pc_wrap) begin
                        pc_d    = '0;
                        count_d = step_val;
                    end else begin
                        pc_d = pc_q + PS_WIDTH'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously while reset is low
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            term_q  <= '0;
            pc_q    <= '0;
            ps_q    <= '0;
            down_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            term_q  <= term_d;
            pc_q    <= pc_d;
            ps_q    <= ps_d;
            down_q  <= down_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign done      = (state_q == ST_DONE);
    assign count_out = count_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_counter_run_controller.sv
// tb_counter_run_controller: directed scenarios with hand-derived expectations,
// plus randomized traffic checked against an arithmetic reference model. The
// model derives the count from the number of effective run edges divided by
// (prescale+1).
module tb_counter_run_controller;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_start_val;
    logic [7:0] cmd_term_val;
    logic [3:0] cmd_prescale;
    logic       cmd_down;
    logic       pause;
    logic       abort;
    logic [7:0] count_out;
    logic       busy;
    logic       done;
    logic [1:0] state_out;

    int total;
    int bad;

    // Reference model: mode 0 idle, 1 run, 2 pause, 3 done
    int         m_mode;
    logic [7:0] m_count;
    logic [7:0] m_start;
    logic [7:0] m_term;
    int         m_p;
    logic       m_down;
    int         m_eff;

    counter_run_controller #(.WIDTH(8), .PS_WIDTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_start_val (cmd_start_val),
        .cmd_term_val  (cmd_term_val),
        .cmd_prescale  (cmd_prescale),
        .cmd_down      (cmd_down),
        .pause         (pause),
        .abort         (abort),
        .count_out     (count_out),
        .busy          (busy),
        .done          (done),
        .state_out     (state_out)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    function automatic logic [7:0] model_pos();
        int         steps;
        logic [7:0] s8;
        steps = m_eff / (m_p + 1);
        s8    = 8'(steps);
        return m_down ? (m_start - s8) : (m_start + s8);
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_count = 8'h00;
        m_start = 8'h00;
        m_term  = 8'h00;
        m_p     = 0;
        m_down  = 1'b0;
        m_eff   = 0;
    endtask

    task automatic model_edge();
        case (m_mode)
            0: begin
                if (cmd_valid) begin
                    m_start = cmd_start_val;
                    m_term  = cmd_term_val;
                    m_p     = int'(cmd_prescale);
                    m_down  = cmd_down;
                    m_eff   = 0;
                    m_count = cmd_start_val;
                    m_mode  = 1;
                end
            end
            1: begin
                if (abort) m_mode = 0;
                else if (m_count == m_term) m_mode = 3;
                else if (pause) m_mode = 2;
                else begin
                    m_eff++;
                    m_count = model_pos();
                end
            end
            2: begin
                if (abort) m_mode = 0;
                else if (!pause) begin
                    m_mode = 1;
                    m_eff++;
                    m_count = model_pos();
                end
            end
            default: m_mode = 0;
        endcase
    endtask

    task automatic drive(input logic v, input logic [7:0] s, input logic [7:0] t,
                         input logic [3:0] p, input logic d, input logic ps, input logic ab);
        cmd_valid     = v;
        cmd_start_val = s;
        cmd_term_val  = t;
        cmd_prescale  = p;
        cmd_down      = d;
        pause         = ps;
        abort         = ab;
    endtask

    task automatic drive_idle();
        drive(1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b0;
        #3;
        total++; if (count_out !== 8'h00) begin bad++; $display("[TB] FAIL reset_count: got %0h want 00", count_out); end
        total++; if (state_out !== 2'd0) begin bad++; $display("[TB] FAIL reset_state: got %0d want 0", state_out); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %b want 1", cmd_ready); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy_done: got %b%b want 00", busy, done); end
        #4;
        reset = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic test_basic_up();
        logic [7:0] exp_c [6] = '{8'd3, 8'd4, 8'd5, 8'd6, 8'd6, 8'd6};
        logic [1:0] exp_s [6] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd0};
        drive(1'b1, 8'd3, 8'd6, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        drive_idle();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            total++; if (count_out !== exp_c[i]) begin bad++; $display("[TB] FAIL up_count[%0d]: got %0h want %0h", i, count_out, exp_c[i]); end
            total++; if (state_out !== exp_s[i]) begin bad++; $display("[TB] FAIL up_state[%0d]: got %0d want %0d", i, state_out, exp_s[i]); end
            total++; if (done !== (exp_s[i] == 2'd3)) begin bad++; $display("[TB] FAIL up_done[%0d]: got %b want %b", i, done, exp_s[i] == 2'd3); end
            total++; if (cmd_ready !== (exp_s[i] == 2'd0)) begin bad++; $display("[TB] FAIL up_ready[%0d]: got %b want %b", i, cmd_ready, exp_s[i] == 2'd0); end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_c [6] = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h01, 8'h01};
        logic [1:0] exp_s [6] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd0};
        int dones = 0;
        drive(1'b1, 8'hFE, 8'h01, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        drive_idle();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            if (done === 1'b1) dones++;
            if (i < 6) begin
                total++; if (count_out !== exp_c[i]) begin bad++; $display("[TB] FAIL wrap_count[%0d]: got %0h want %0h", i, count_out, exp_c[i]); end
                total++; if (state_out !== exp_s[i]) begin bad++; $display("[TB] FAIL wrap_state[%0d]: got %0d want %0d", i, state_out, exp_s[i]); end
            end
        end
        total++; if (dones != 1) begin bad++; $display("[TB] FAIL wrap_done_pulses: got %0d want 1", dones); end
    endtask

    task automatic test_down_prescale();
        logic [7:0] exp_c;
        logic [1:0] exp_s;
        drive(1'b1, 8'd2, 8'hFE, 4'd2, 1'b1, 1'b0, 1'b0);
        tick();
        drive_idle();
        for (int i = 0; i < 15; i++) begin
            if (i > 0) tick();
            exp_c = (i <= 12) ? 8'(2 - i / 3) : 8'hFE;
            exp_s = (i <= 12) ? 2'd1 : ((i == 13) ? 2'd3 : 2'd0);
            total++; if (count_out !== exp_c) begin bad++; $display("[TB] FAIL down_count[%0d]: got %0h want %0h", i, count_out, exp_c); end
            total++; if (state_out !== exp_s) begin bad++; $display("[TB] FAIL down_state[%0d]: got %0d want %0d", i, state_out, exp_s); end
        end
    endtask

    task automatic test_pause();
        int cyc;
        int found;
        int done_at [2];
        // run 0 has no pause; run 1 holds pause high across edges 3..7
        for (int run = 0; run < 2; run++) begin
            drive(1'b1, 8'd0, 8'd4, 4'd1, 1'b0, 1'b0, 1'b0);
            tick();
            drive_idle();
            cyc = 0;
            found = 0;
            while (cyc < 60 && found == 0) begin
                pause = (run == 1) && (cyc >= 2) && (cyc <= 6);
                tick();
                cyc++;
                if (run == 1 && cyc >= 3 && cyc <= 7) begin
                    total++; if (state_out !== 2'd2 || busy !== 1'b1) begin bad++; $display("[TB] FAIL pause_state[%0d]: got state %0d busy %b want 2 1", cyc, state_out, busy); end
                    total++; if (count_out !== 8'd1) begin bad++; $display("[TB] FAIL pause_count[%0d]: got %0h want 01", cyc, count_out); end
                end
                if (done === 1'b1) found = 1;
            end
            pause = 1'b0;
            done_at[run] = (found != 0) ? cyc : -1;
            tick();
        end
        total++; if (done_at[0] != 9) begin bad++; $display("[TB] FAIL pause_baseline: got %0d want 9", done_at[0]); end
        total++; if (done_at[1] != 14) begin bad++; $display("[TB] FAIL pause_delay: got %0d want 14", done_at[1]); end
    endtask

    task automatic test_abort_pause();
        int dones = 0;
        drive(1'b1, 8'd10, 8'd20, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h99, 8'h99, 4'd5, 1'b1, 1'b0, 1'b0);
        tick(); if (done === 1'b1) dones++;
        tick(); if (done === 1'b1) dones++;
        total++; if (count_out !== 8'd12 || state_out !== 2'd1) begin bad++; $display("[TB] FAIL ignore_cmd: got %0h/%0d want 0c/1", count_out, state_out); end
        drive(1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0);
        tick(); if (done === 1'b1) dones++;
        tick(); if (done === 1'b1) dones++;
        total++; if (state_out !== 2'd2 || count_out !== 8'd12) begin bad++; $display("[TB] FAIL abort_pre_state: got %0d/%0h want 2/0c", state_out, count_out); end
        abort = 1'b1;
        tick(); if (done === 1'b1) dones++;
        total++; if (state_out !== 2'd0 || count_out !== 8'd12) begin bad++; $display("[TB] FAIL abort_idle: got %0d/%0h want 0/0c", state_out, count_out); end
        pause = 1'b0;
        tick(); if (done === 1'b1) dones++;
        tick(); if (done === 1'b1) dones++;
        total++; if (state_out !== 2'd0 || count_out !== 8'd12 || cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL abort_in_idle: got %0d/%0h/%b want 0/0c/1", state_out, count_out, cmd_ready); end
        total++; if (dones != 0) begin bad++; $display("[TB] FAIL abort_no_done: got %0d want 0", dones); end
        drive_idle();
    endtask

    task automatic test_equal_start_term();
        drive(1'b1, 8'h40, 8'h40, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        tick();
        drive_idle();
        total++; if (state_out !== 2'd1 || done !== 1'b0) begin bad++; $display("[TB] FAIL eq_first: got %0d/%b want 1/0", state_out, done); end
        tick();
        total++; if (done !== 1'b1 || count_out !== 8'h40) begin bad++; $display("[TB] FAIL eq_done: got %b/%0h want 1/40", done, count_out); end
        tick();
        total++; if (state_out !== 2'd0 || count_out !== 8'h40) begin bad++; $display("[TB] FAIL eq_idle: got %0d/%0h want 0/40", state_out, count_out); end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 8'd5, 8'd200, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        drive_idle();
        tick();
        tick();
        total++; if (count_out !== 8'd7) begin bad++; $display("[TB] FAIL areset_pre: got %0h want 07", count_out); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (count_out !== 8'h00 || state_out !== 2'd0) begin bad++; $display("[TB] FAIL areset_async: got %0h/%0d want 00/0", count_out, state_out); end
        total++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin bad++; $display("[TB] FAIL areset_flags: got %b%b%b want 010", busy, cmd_ready, done); end
        #2;
        reset = 1'b1;
        model_reset();
        drive(1'b1, 8'd9, 8'd11, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        drive_idle();
        total++; if (count_out !== 8'd9 || state_out !== 2'd1) begin bad++; $display("[TB] FAIL areset_resume: got %0h/%0d want 09/1", count_out, state_out); end
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_random();
        logic [7:0] s;
        logic       d;
        logic [7:0] k;
        for (int i = 0; i < 400; i++) begin
            s = 8'($urandom);
            d = 1'($urandom_range(0, 1));
            k = 8'($urandom_range(0, 5));
            drive(($urandom % 3) == 0, s, d ? (s - k) : (s + k), 4'($urandom_range(0, 3)), d,
                  ($urandom % 4) == 0, ($urandom % 16) == 0);
            tick();
            total++; if (count_out !== m_count) begin bad++; $display("[TB] FAIL rnd_count[%0d]: got %0h want %0h", i, count_out, m_count); end
            total++; if (state_out !== 2'(m_mode)) begin bad++; $display("[TB] FAIL rnd_state[%0d]: got %0d want %0d", i, state_out, m_mode); end
            total++; if (busy !== (m_mode == 1 || m_mode == 2)) begin bad++; $display("[TB] FAIL rnd_busy[%0d]: got %b want %b", i, busy, m_mode == 1 || m_mode == 2); end
            total++; if (done !== (m_mode == 3)) begin bad++; $display("[TB] FAIL rnd_done[%0d]: got %b want %b", i, done, m_mode == 3); end
            total++; if (cmd_ready !== (m_mode == 0)) begin bad++; $display("[TB] FAIL rnd_ready[%0d]: got %b want %b", i, cmd_ready, m_mode == 0); end
        end
        drive_idle();
    endtask

    // Scenario sequence
    initial begin
        clk   = 1'b0;
        total = 0;
        bad   = 0;
        model_reset();
        test_reset();
        test_basic_up();
        test_wrap();
        test_down_prescale();
        test_pause();
        test_abort_pause();
        test_equal_start_term();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a stuck run
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish want finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
